// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between a pad-side master and the register-bank peripheral.
// The peripheral uses the slave modport; the master modport drives clock, data and select.
interface spi_reg_bank_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
    modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: oversampled pins, R/W + address + data frames, read-back on cipo,
// frame-length checking with a saturating error counter.
module spi_reg_bank #(
    parameter int                 ADDR_W    = 7,
    parameter int                 DATA_W    = 8,
    parameter int                 NUM_REGS  = 5,
    parameter logic [DATA_W-1:0]  RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_reg_bank_if.slave                spi,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [7:0]                   err_cnt
);

    localparam int CMD_W   = 1 + ADDR_W;
    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int SHIFT_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Returns {hit, data}; data is zero for unimplemented addresses.
    function automatic logic [DATA_W:0] reg_lookup(
        input logic [ADDR_W-1:0]          a,
        input logic [NUM_REGS*DATA_W-1:0] q
    );
        logic [DATA_W:0] r;
        r = {(DATA_W+1){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_W'(i)) begin
                r = {1'b1, q[i*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    logic [2:0]                 sclk_sync_r;
    logic [1:0]                 copi_sync_r;
    logic [2:0]                 ncs_sync_r;

    state_t                     state_r, state_n;
    logic [CNT_W-1:0]           bit_cnt_r, bit_cnt_n;
    logic [SHIFT_W-1:0]         rx_r, rx_n;
    logic [DATA_W-1:0]          tx_r, tx_n;
    logic                       is_wr_r, is_wr_n;
    logic [ADDR_W-1:0]          addr_r, addr_n;
    logic                       cipo_r, cipo_n;
    logic                       cipo_oe_r;

    logic [NUM_REGS*DATA_W-1:0] regs_r;
    logic                       wr_pulse_r;
    logic [ADDR_W-1:0]          wr_addr_r;
    logic [7:0]                 err_cnt_r;

    logic                       sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s;
    logic [SHIFT_W-1:0]         rx_shift_s;
    logic [CMD_W-1:0]           cmd_s;
    logic [DATA_W:0]            rd_lookup_s;
    logic [DATA_W:0]            commit_lookup_s;
    logic                       commit_s, err_inc_s;

    assign sclk_rise_s     = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign sclk_fall_s     = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign ncs_rise_s      = ncs_sync_r[1] & ~ncs_sync_r[2];
    assign ncs_fall_s      = ~ncs_sync_r[1] & ncs_sync_r[2];
    assign rx_shift_s      = {rx_r[SHIFT_W-2:0], copi_sync_r[1]};
    assign cmd_s           = rx_shift_s[CMD_W-1:0];
    assign rd_lookup_s     = reg_lookup(cmd_s[ADDR_W-1:0], regs_r);
    assign commit_lookup_s = reg_lookup(addr_r, regs_r);

    // Pin synchronisers; the third sclk/ncs stage exists only for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= 3'b000;
            copi_sync_r <= 2'b00;
            ncs_sync_r  <= 3'b000;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], spi.sclk};
            copi_sync_r <= {copi_sync_r[0], spi.copi};
            ncs_sync_r  <= {ncs_sync_r[1:0], spi.ncs};
        end
    end

    // Frame FSM state and shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= {CNT_W{1'b0}};
            rx_r      <= {SHIFT_W{1'b0}};
            tx_r      <= {DATA_W{1'b0}};
            is_wr_r   <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            cipo_r    <= 1'b0;
            cipo_oe_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            rx_r      <= rx_n;
            tx_r      <= tx_n;
            is_wr_r   <= is_wr_n;
            addr_r    <= addr_n;
            cipo_r    <= cipo_n;
            cipo_oe_r <= ~ncs_sync_r[1];
        end
    end

    // Next-state, bit collection, read-data shifting and commit/error decisions.
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        rx_n      = rx_r;
        tx_n      = tx_r;
        is_wr_n   = is_wr_r;
        addr_n    = addr_r;
        cipo_n    = 1'b0;
        commit_s  = 1'b0;
        err_inc_s = 1'b0;

        if (ncs_fall_s) begin
            // A new select edge always restarts framing, even mid-frame.
            state_n   = ST_CMD;
            bit_cnt_n = {CNT_W{1'b0}};
            rx_n      = {SHIFT_W{1'b0}};
            tx_n      = {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n = ST_IDLE;
                end
                ST_CMD: begin
                    if (ncs_rise_s) begin
                        state_n   = ST_IDLE;
                        err_inc_s = 1'b1;
                    end else if (sclk_rise_s) begin
                        rx_n = rx_shift_s;
                        if (bit_cnt_r == CNT_W'(CMD_W - 1)) begin
                            state_n   = ST_DATA;
                            bit_cnt_n = {CNT_W{1'b0}};
                            is_wr_n   = cmd_s[CMD_W-1];
                            addr_n    = cmd_s[ADDR_W-1:0];
                            tx_n      = cmd_s[CMD_W-1] ? {DATA_W{1'b0}} : rd_lookup_s[DATA_W-1:0];
                        end else begin
                            bit_cnt_n = bit_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_n = ST_CMD;
                    end
                end
                ST_DATA, ST_HOLD: begin
                    if (is_wr_r) begin
                        cipo_n = 1'b0;
                    end else if (sclk_fall_s) begin
                        cipo_n = tx_r[DATA_W-1];
                        tx_n   = {tx_r[DATA_W-2:0], 1'b0};
                    end else begin
                        cipo_n = cipo_r;
                    end

                    if (ncs_rise_s) begin
                        state_n   = ST_IDLE;
                        cipo_n    = 1'b0;
                        commit_s  = (state_r == ST_HOLD) && is_wr_r && commit_lookup_s[DATA_W];
                        err_inc_s = (state_r == ST_DATA);
                    end else if (sclk_rise_s && (state_r == ST_HOLD)) begin
                        state_n = ST_ERR;
                        cipo_n  = 1'b0;
                    end else if (sclk_rise_s) begin
                        rx_n = rx_shift_s;
                        if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                            state_n   = ST_HOLD;
                            bit_cnt_n = {CNT_W{1'b0}};
                        end else begin
                            bit_cnt_n = bit_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_ERR: begin
                    if (ncs_rise_s) begin
                        state_n   = ST_IDLE;
                        err_inc_s = 1'b1;
                    end else begin
                        state_n = ST_ERR;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Register file, commit strobe and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_r     <= {NUM_REGS{RESET_VAL}};
            wr_pulse_r <= 1'b0;
            wr_addr_r  <= {ADDR_W{1'b0}};
            err_cnt_r  <= 8'd0;
        end else begin
            wr_pulse_r <= commit_s;
            if (commit_s) begin
                wr_addr_r <= addr_r;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr_r == ADDR_W'(i)) begin
                        regs_r[i*DATA_W +: DATA_W] <= rx_r[DATA_W-1:0];
                    end
                end
            end
            if (err_inc_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign reg_q       = regs_r;
    assign wr_pulse    = wr_pulse_r;
    assign wr_addr     = wr_addr_r;
    assign err_cnt     = err_cnt_r;
    assign spi.cipo    = cipo_r;
    assign spi.cipo_oe = cipo_oe_r;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed-vector bench for spi_reg_bank: writes, read-back, out-of-range addresses,
// short/long frames, error saturation and mid-frame reset.
module tb_spi_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] reg_q;
    logic        wr_pulse;
    logic [6:0]  wr_addr;
    logic [7:0]  err_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    int          pulse_cnt = 0;
    logic [7:0]  rd;

    spi_reg_bank_if spi ();

    spi_reg_bank #(.ADDR_W(7), .DATA_W(8), .NUM_REGS(5), .RESET_VAL(8'h00)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi      (spi),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Counts clock cycles with wr_pulse high, so pulse width is checked too.
    always @(negedge clk) if (wr_pulse === 1'b1) pulse_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start();
        spi.ncs = 1'b0;
        wait_clk(5);
    endtask

    task automatic spi_bits(input logic [31:0] val, input int nbits, output logic [7:0] rdata);
        rdata = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi.copi = val[nbits-1-i];
            wait_clk(10);
            rdata = {rdata[6:0], spi.cipo};
            spi.sclk = 1'b1;
            wait_clk(10);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        wait_clk(10);
        spi.ncs = 1'b1;
        wait_clk(10);
    endtask

    task automatic spi_frame(input logic [31:0] val, input int nbits, output logic [7:0] rdata);
        spi_start();
        spi_bits(val, nbits, rdata);
        spi_end();
    endtask

    task automatic test_reset();
        wait_clk(3);
        n_vec++; if (reg_q !== 40'h0) begin n_bad++; $display("FAIL reset_reg_q got %h want %h", reg_q, 40'h0); end
        n_vec++; if (spi.cipo !== 1'b0) begin n_bad++; $display("FAIL reset_cipo got %b want 0", spi.cipo); end
        n_vec++; if (spi.cipo_oe !== 1'b0) begin n_bad++; $display("FAIL reset_cipo_oe got %b want 0", spi.cipo_oe); end
        n_vec++; if (wr_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_wr_pulse got %b want 0", wr_pulse); end
        n_vec++; if (wr_addr !== 7'd0) begin n_bad++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        n_vec++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        rst_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_write();
        int base;
        bit seen;
        base = pulse_cnt;
        seen = 1'b0;
        spi_start();
        spi_bits(32'h82A5, 16, rd);
        wait_clk(10);
        spi.ncs = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wr_pulse === 1'b1) begin
                seen = 1'b1;
                n_vec++; if (reg_q[23:16] !== 8'hA5) begin n_bad++; $display("FAIL write_reg2_at_pulse got %h want a5", reg_q[23:16]); end
                n_vec++; if (wr_addr !== 7'd2) begin n_bad++; $display("FAIL write_wr_addr got %0d want 2", wr_addr); end
            end
        end
        n_vec++; if (!seen) begin n_bad++; $display("FAIL write_pulse_timeout got none want 1 pulse"); end
        wait_clk(10);
        n_vec++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL write_pulse_cycles got %0d want 1", pulse_cnt - base); end
        n_vec++; if (reg_q !== 40'h0000A50000) begin n_bad++; $display("FAIL write_reg_q got %h want 0000a50000", reg_q); end
        n_vec++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL write_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_read();
        int base;
        base = pulse_cnt;
        spi_start();
        n_vec++; if (spi.cipo_oe !== 1'b1) begin n_bad++; $display("FAIL read_cipo_oe_on got %b want 1", spi.cipo_oe); end
        spi_bits(32'h0200, 16, rd);
        spi_end();
        n_vec++; if (rd !== 8'hA5) begin n_bad++; $display("FAIL read_data got %h want a5", rd); end
        n_vec++; if (reg_q !== 40'h0000A50000) begin n_bad++; $display("FAIL read_reg_q got %h want 0000a50000", reg_q); end
        n_vec++; if (pulse_cnt !== base) begin n_bad++; $display("FAIL read_no_pulse got %0d want %0d", pulse_cnt, base); end
        n_vec++; if (spi.cipo !== 1'b0) begin n_bad++; $display("FAIL read_cipo_idle got %b want 0", spi.cipo); end
        n_vec++; if (spi.cipo_oe !== 1'b0) begin n_bad++; $display("FAIL read_cipo_oe_off got %b want 0", spi.cipo_oe); end
    endtask

    task automatic test_bad_addr();
        int base;
        base = pulse_cnt;
        spi_frame(32'h8733, 16, rd);
        n_vec++; if (reg_q !== 40'h0000A50000) begin n_bad++; $display("FAIL badaddr_reg_q got %h want 0000a50000", reg_q); end
        n_vec++; if (pulse_cnt !== base) begin n_bad++; $display("FAIL badaddr_no_pulse got %0d want %0d", pulse_cnt, base); end
        n_vec++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL badaddr_err_cnt got %0d want 0", err_cnt); end
        spi_frame(32'h0700, 16, rd);
        n_vec++; if (rd !== 8'h00) begin n_bad++; $display("FAIL badaddr_read got %h want 00", rd); end
    endtask

    task automatic test_frame_length();
        int base;
        base = pulse_cnt;
        spi_frame(32'h0204, 10, rd);
        n_vec++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL short_err_cnt got %0d want 1", err_cnt); end
        n_vec++; if (reg_q !== 40'h0000A50000) begin n_bad++; $display("FAIL short_reg_q got %h want 0000a50000", reg_q); end
        spi_frame(32'h10222, 17, rd);
        n_vec++; if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL long_err_cnt got %0d want 2", err_cnt); end
        n_vec++; if (reg_q !== 40'h0000A50000) begin n_bad++; $display("FAIL long_reg_q got %h want 0000a50000", reg_q); end
        n_vec++; if (pulse_cnt !== base) begin n_bad++; $display("FAIL length_no_pulse got %0d want %0d", pulse_cnt, base); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            spi.ncs = 1'b0;
            wait_clk(6);
            spi.ncs = 1'b1;
            wait_clk(6);
            if (i == 249) begin
                n_vec++; if (err_cnt !== 8'd252) begin n_bad++; $display("FAIL sat_midway got %0d want 252", err_cnt); end
            end
        end
        n_vec++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_final got %0d want 255", err_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        spi_frame(32'h805A, 16, rd);
        n_vec++; if (reg_q !== 40'h0000A5005A) begin n_bad++; $display("FAIL midrst_pre_reg_q got %h want 0000a5005a", reg_q); end
        base = pulse_cnt;
        spi_start();
        spi_bits(32'h80, 8, rd);
        rst_n = 1'b0;
        wait_clk(3);
        n_vec++; if (reg_q !== 40'h0) begin n_bad++; $display("FAIL midrst_reg_q got %h want 0", reg_q); end
        n_vec++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_err_cnt got %0d want 0", err_cnt); end
        spi.ncs = 1'b1;
        rst_n = 1'b1;
        wait_clk(10);
        n_vec++; if (pulse_cnt !== base) begin n_bad++; $display("FAIL midrst_no_pulse got %0d want %0d", pulse_cnt, base); end
        spi_frame(32'h80C3, 16, rd);
        n_vec++; if (reg_q !== 40'h00000000C3) begin n_bad++; $display("FAIL midrst_post_reg_q got %h want 00000000c3", reg_q); end
        n_vec++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL midrst_post_pulse got %0d want 1", pulse_cnt - base); end
        n_vec++; if (wr_addr !== 7'd0) begin n_bad++; $display("FAIL midrst_wr_addr got %0d want 0", wr_addr); end
        n_vec++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_post_err got %0d want 0", err_cnt); end
    endtask

    initial begin
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        spi.ncs  = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_frame_length();
        test_saturate();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
